// File: rtl/gate_pkg.sv
// gate_pkg: shared encodings for the gate sweep controller and its reference model.
package gate_pkg;
    localparam int DEF_WIDTH = 10;
    localparam logic [1:0] OP_OR  = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NOR = 2'd3;
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;
endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: reference reduction of a gate input vector selected by op.
module gate_ref_model
    import gate_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [1:0]       op,
    output logic             expected
);
    always_comb expected = op == OP_OR  ? |vec :
                           op == OP_AND ? &vec :
                           op == OP_XOR ? ^vec : ~|vec;
endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: exhaustive vector sweep of a combinational gate with settle delay,
// saturating mismatch count and first-failure capture.
module gate_sweep_ctrl
    import gate_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] vec,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] first_fail,
    output logic             fail_strobe
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;

    state_t state_q, state_d;
    logic [WIDTH-1:0] vec_q, vec_d, ff_q, ff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [1:0] op_q, op_d;
    logic expected, mismatch;

    gate_ref_model #(.WIDTH(WIDTH)) u_ref (.vec(vec_q), .op(op_q), .expected(expected));

    assign mismatch = state_q == ST_CHECK && dut_out != expected;
    assign busy = state_q == ST_SETTLE || state_q == ST_CHECK;

    always_comb begin
        state_d = state_q;
        vec_d = vec_q;
        ff_d = ff_q;
        cnt_d = cnt_q;
        err_d = err_q;
        op_d = op_q;
        if (busy && abort) begin
            state_d = ST_IDLE;
        end else if (!busy && start) begin
            state_d = ST_SETTLE;
            vec_d = '0;
            ff_d = '0;
            err_d = '0;
            op_d = op;
            cnt_d = CW'(SETTLE - 1);
        end else if (state_q == ST_SETTLE) begin
            if (cnt_q == '0) state_d = ST_CHECK;
            else cnt_d = cnt_q - 1'b1;
        end else if (state_q == ST_CHECK) begin
            // a zero count means no mismatch yet this run, since it saturates rather than wraps
            if (mismatch) begin
                if (err_q == '0) ff_d = vec_q;
                if (err_q != '1) err_d = err_q + 1'b1;
            end
            if (vec_q == '1) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_SETTLE;
                vec_d = vec_q + 1'b1;
                cnt_d = CW'(SETTLE - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q <= '0;
            ff_q <= '0;
            cnt_q <= '0;
            err_q <= '0;
            op_q <= OP_OR;
        end else begin
            state_q <= state_d;
            vec_q <= vec_d;
            ff_q <= ff_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            op_q <= op_d;
        end
    end

    assign vec = vec_q;
    assign done = state_q == ST_DONE;
    assign pass = done && err_q == '0;
    assign err_count = err_q;
    assign first_fail = ff_q;
    assign fail_strobe = mismatch;
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: two controller configurations checked every cycle against a
// cycle-count based sweep model, plus literal expectations for the directed runs.
module tb_gate_sweep_ctrl;
    logic clk = 1'b0;
    logic rst, start, abort;
    logic [1:0] op, gop;
    int mode;
    int n_chk = 0, n_fail = 0;

    int vec_a[2], err_a[2], ff_a[2], nstr[2];
    logic [1:0] busy_a, done_a, pass_a, fs_a, dout_a;

    int pw[2] = '{10, 6};
    int ps[2] = '{1, 3};
    int pe[2] = '{11, 4};

    always #5 clk = ~clk;

    function automatic logic gate_fn(input logic [1:0] o, input int v, input int w);
        int n = 0;
        for (int b = 0; b < w; b++) n += (v >> b) & 1;
        return o == 2'd0 ? n > 0 : o == 2'd1 ? n == w : o == 2'd2 ? n % 2 == 1 : n == 0;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int W = g == 0 ? 10 : 6;
        localparam int S = g == 0 ? 1 : 3;
        localparam int E = g == 0 ? 11 : 4;
        logic [W-1:0] vec, ff;
        logic [E-1:0] err;
        logic busy, done, pass, fs, dout, d1, d2, rb;
        gate_sweep_ctrl #(.WIDTH(W), .SETTLE(S), .ERR_W(E)) u_dut (
            .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op), .vec(vec),
            .dut_out(dout), .busy(busy), .done(done), .pass(pass), .err_count(err),
            .first_fail(ff), .fail_strobe(fs)
        );
        always @(posedge clk) begin
            d1 <= ^vec;
            d2 <= d1;
            rb <= 1'($urandom);
        end
        assign dout = mode == 0 ? gate_fn(gop, int'(vec), W) : mode == 1 ? |vec[W-2:0] :
                      mode == 2 ? 1'b0 : mode == 3 ? d2 : rb;
        assign vec_a[g] = int'(vec);
        assign err_a[g] = int'(err);
        assign ff_a[g] = int'(ff);
        assign busy_a[g] = busy;
        assign done_a[g] = done;
        assign pass_a[g] = pass;
        assign fs_a[g] = fs;
        assign dout_a[g] = dout;
    end

    bit m_run[2], m_done[2], m_seen[2];
    int m_j[2], m_vec[2], m_err[2], m_ff[2];
    logic [1:0] m_op[2];

    // model: j counts edges since the accepted start; every (S+1)th cycle is a check
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_done[i] = 0; m_seen[i] = 0;
            m_j[i] = 0; m_vec[i] = 0; m_err[i] = 0; m_ff[i] = 0; m_op[i] = 2'd0;
            nstr[i] = 0;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                bit chk;
                chk = m_run[i] && m_j[i] % (ps[i] + 1) == 0;
                check($sformatf("vec%0d", i), vec_a[i], m_vec[i]);
                check($sformatf("busy%0d", i), int'(busy_a[i]), int'(m_run[i]));
                check($sformatf("done%0d", i), int'(done_a[i]), int'(m_done[i]));
                check($sformatf("pass%0d", i), int'(pass_a[i]), int'(m_done[i] && m_err[i] == 0));
                check($sformatf("err%0d", i), err_a[i], m_err[i]);
                check($sformatf("first_fail%0d", i), ff_a[i], m_ff[i]);
                check($sformatf("strobe%0d", i), int'(fs_a[i]),
                      int'(chk && dout_a[i] != gate_fn(m_op[i], m_vec[i], pw[i])));
                if (fs_a[i]) nstr[i]++;
            end
            @(negedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    m_run[i] = 0; m_done[i] = 0; m_seen[i] = 0;
                    m_j[i] = 0; m_vec[i] = 0; m_err[i] = 0; m_ff[i] = 0; m_op[i] = 2'd0;
                end else if (m_run[i] && abort) begin
                    m_run[i] = 0; m_done[i] = 0;
                end else if (!m_run[i] && start) begin
                    m_run[i] = 1; m_done[i] = 0; m_seen[i] = 0;
                    m_j[i] = 1; m_vec[i] = 0; m_err[i] = 0; m_ff[i] = 0; m_op[i] = op;
                end else if (m_run[i]) begin
                    bit chk;
                    chk = m_j[i] % (ps[i] + 1) == 0;
                    if (chk && dout_a[i] != gate_fn(m_op[i], m_vec[i], pw[i])) begin
                        if (!m_seen[i]) m_ff[i] = m_vec[i];
                        m_seen[i] = 1;
                        if (m_err[i] < (1 << pe[i]) - 1) m_err[i]++;
                    end
                    if (chk && m_vec[i] == (1 << pw[i]) - 1) begin
                        m_run[i] = 0; m_done[i] = 1;
                    end else begin
                        m_j[i]++;
                        m_vec[i] = (m_j[i] - 1) / (ps[i] + 1);
                    end
                end
            end
        end
    end

    task automatic run_both(input int md, input logic [1:0] o, output int k0, output int k1,
                            output int s0, output int s1);
        int b0, b1;
        @(negedge clk);
        mode = md; gop = o; op = o; start = 1'b1;
        @(posedge clk);
        #2;
        b0 = nstr[0]; b1 = nstr[1];
        k0 = 0; k1 = 0;
        for (int c = 1; c <= 5000 && (k0 == 0 || k1 == 0); c++) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
            #2;
            if (k0 == 0 && done_a[0]) k0 = c;
            if (k1 == 0 && done_a[1]) k1 = c;
        end
        s0 = nstr[0] - b0; s1 = nstr[1] - b1;
    endtask

    task automatic check_reset(input string nm);
        check({nm, "_vec"}, vec_a[0], 0);
        check({nm, "_busy"}, int'(busy_a[0]), 0);
        check({nm, "_done"}, int'(done_a[0]), 0);
        check({nm, "_pass"}, int'(pass_a[0]), 0);
        check({nm, "_err"}, err_a[0], 0);
        check({nm, "_ff"}, ff_a[0], 0);
        check({nm, "_strobe"}, int'(fs_a[0]), 0);
    endtask

    initial begin
        int k0, k1, s0, s1, c;
        rst = 1'b1; start = 1'b0; abort = 1'b0; op = 2'd0; gop = 2'd0; mode = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check_reset("reset");

        run_both(0, 2'd0, k0, k1, s0, s1);
        check("ideal_len0", k0, 2048);
        check("ideal_len1", k1, 256);
        check("ideal_pass0", int'(pass_a[0]), 1);
        check("ideal_err0", err_a[0], 0);
        check("ideal_strobes0", s0, 0);

        run_both(1, 2'd0, k0, k1, s0, s1);
        check("msb_err0", err_a[0], 1);
        check("msb_ff0", ff_a[0], 'h200);
        check("msb_pass0", int'(pass_a[0]), 0);
        check("msb_strobes0", s0, 1);
        check("msb_ff1", ff_a[1], 'h20);

        run_both(2, 2'd0, k0, k1, s0, s1);
        check("stuck_err0", err_a[0], 1023);
        check("stuck_ff0", ff_a[0], 1);
        check("stuck_err1_sat", err_a[1], 15);
        check("stuck_ff1", ff_a[1], 1);

        run_both(3, 2'd2, k0, k1, s0, s1);
        check("xor_len1", k1, 256);
        check("xor_pass1", int'(pass_a[1]), 1);
        check("xor_pass0", int'(pass_a[0]), 0);

        @(negedge clk);
        mode = 2; op = 2'd0; start = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
            #2;
            c++;
        end while (vec_a[0] != 'h50 && c < 1000);
        @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(posedge clk);
        #2;
        check("abort_busy", int'(busy_a[0]), 0);
        check("abort_done", int'(done_a[0]), 0);
        check("abort_vec", vec_a[0], 'h50);
        check("abort_err", err_a[0], 79);
        @(negedge clk);
        abort = 1'b0; start = 1'b1;
        @(posedge clk);
        #2;
        check("restart_vec", vec_a[0], 0);
        check("restart_err", err_a[0], 0);
        check("restart_busy", int'(busy_a[0]), 1);

        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = i % 7 == 3;
        end
        c = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
            #2;
            c++;
        end while (!fs_a[0] && c < 500);
        check("mid_check_seen", int'(fs_a[0]), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check_reset("midrst");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (i % 1500 == 0) begin
                mode = $urandom_range(0, 4);
                gop = 2'($urandom);
            end
            start = $urandom_range(0, 39) == 0;
            abort = $urandom_range(0, 1499) == 0;
            rst = $urandom_range(0, 4999) == 0;
            op = 2'($urandom);
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Sequencer that exhaustively drives a WIDTH-input single-output combinational gate under test (DUT).
- Walks every input vector 0..2^WIDTH-1, waits a settle interval, then compares the DUT output against a reference reduction function.
- Counts mismatches and records the first failing vector.
- Replaces free-running stimulus and one-shot checking in gate benches with a start/done-controlled, cycle-exact controller usable on-board (results go to LEDs or a readout).

Parameters:
- WIDTH, 10, number of DUT inputs (1..16).
- SETTLE, 1, cycles the vector is held before sampling (>=1).
- ERR_W, 11, width of the mismatch counter (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; accepted only in IDLE or DONE.
- abort  in  1  stops a run; ignored when not busy.
- op  in  2  reference function, latched at start: 0=OR, 1=AND, 2=XOR, 3=NOR.
- vec  out  WIDTH  input vector driven to the DUT.
- dut_out  in  1  DUT output.
- busy  out  1  high in SETTLE/CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid when done; 1 iff err_count==0.
- err_count  out  ERR_W  mismatches in the current/last run; saturates at all-ones.
- first_fail  out  WIDTH  first mismatching vector; 0 if none.
- fail_strobe  out  1  one-cycle pulse in any CHECK cycle that mismatches.

Behaviour:
- Reset values: state=IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_strobe=0, latched op=OR.
- Reset mid-run returns to IDLE on the next edge. All results are cleared.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + start: go to SETTLE, vec=0, err_count=0, first_fail=0, latch op, settle counter=SETTLE-1, done=0.
- SETTLE: if counter==0 go to CHECK, else decrement. SETTLE lasts exactly SETTLE cycles per vector.
- CHECK: sample dut_out and compute expected = op(vec) over all WIDTH bits, bit 0 through bit WIDTH-1 inclusive.
  - On mismatch: pulse fail_strobe; increment err_count, saturating at 2^ERR_W-1. If this is the first mismatch of the run, first_fail=vec.
  - If vec==all-ones, go to DONE with vec held.
  - Otherwise vec++, reload the counter to SETTLE-1, and go to SETTLE.
- Cycles per vector: SETTLE+1. With start sampled at edge t, done rises at edge t+2^WIDTH*(SETTLE+1).
- DONE: done=1, pass=(err_count==0). Holds until start (restart) or rst.
- abort while busy: go to IDLE next edge. err_count and first_fail are retained, done=0, pass=0, vec is held.
- Simultaneous events:
  - rst has top priority.
  - abort beats start.
  - start while busy is ignored.
  - abort and start in the same cycle while busy: abort wins, start is dropped.
- pass is 0 whenever done=0.
- The first-fail flag is internal and cleared at start. A real failure at vector 0 is distinguished from "none" by err_count.

Decomposition:
- Shared package gate_pkg holds:
  - op encodings OP_OR=2'd0, OP_AND=2'd1, OP_XOR=2'd2, OP_NOR=2'd3;
  - FSM state encodings;
  - a constant for the default WIDTH.
- One natural sub-module, gate_ref_model: combinational, inputs vec[WIDTH-1:0] and op, output expected. It is reused by other gate benches.
- The controller holds the FSM, vector counter, settle counter and result registers.

Test Plan:
- Ideal OR DUT, WIDTH=10, SETTLE=1, op=OR, start pulse -> done after exactly 2048 cycles, pass=1, err_count=0, no fail_strobe.
- DUT that ORs only bits 0..8 -> single mismatch at vec=0x200, err_count=1, first_fail=0x200, pass=0, exactly one fail_strobe.
- Stuck-at-0 DUT, op=OR -> err_count=1023, first_fail=0x001. Repeat with ERR_W=4 -> err_count saturates at 15.
- SETTLE=3, op=XOR, DUT=XOR with a 2-cycle output delay -> pass=1, done after 4096 cycles. Same DUT with SETTLE=1 -> pass=0.
- abort at vec=0x050 -> IDLE next cycle, busy=0, done=0, err_count retained. A later start restarts from vec=0 with results cleared.
- rst asserted mid-CHECK -> all outputs at reset values next cycle. start during busy has no effect on vec sequence.
